deserializacion: RTL

- Receive side of the serial link driven by `serializacion`.
- Takes one serial lane at bit rate (`clk_8f`), finds word alignment from the idle comma 0xBC, and locks after a run of consecutive commas.
- Once locked, rebuilds 8-bit parallel words with a valid flag. The bench instantiates one per lane (P2S0, P2S1).

---
 rtl/deserializacion_if.sv | 27 ++
 rtl/deserializacion.sv | 103 ++++++++++
 2 files changed

// File: rtl/deserializacion_if.sv
// Serial lane bundle between a bit source and the deserializer.
// The master drives the serial bit and the slave returns the rebuilt words.
interface deserializacion_if #(
  parameter int unsigned WIDTH = 8
);
  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             word_stb;
  logic             active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  word_stb,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output word_stb,
    output active
  );
endinterface

// File: rtl/deserializacion.sv
// Serial-to-parallel receiver: aligns on the idle comma, locks after BC_COUNT aligned commas,
// then rebuilds WIDTH-bit words (MSB first) with a valid flag and a word strobe.
module deserializacion #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] COMMA    = WIDTH'(8'hBC),
  parameter int unsigned      BC_COUNT = 4
) (
  input logic               clk_8f,
  input logic               reset_L,
  deserializacion_if.slave  lane
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned BcW  = $clog2(BC_COUNT + 1);

  typedef enum logic [1:0] {StSearch, StLocking, StActive} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BcW-1:0]    bc_cnt_q, bc_cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              stb_q, stb_d;
  logic              word_done;
  logic              is_comma;

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= StSearch;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      stb_q     <= stb_d;
    end
  end

  always_comb begin
    sr_d      = {sr_q[WIDTH-2:0], lane.data_in};
    word_done = (bit_cnt_q == CntW'(WIDTH - 1));
    is_comma  = (sr_d == COMMA);
    state_d   = state_q;
    bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    stb_d     = 1'b0;

    unique case (state_q)
      // Bit-granular hunt: any match fixes the word boundary at this edge.
      StSearch: begin
        if (is_comma) begin
          bit_cnt_d = '0;
          bc_cnt_d  = BcW'(1);
          state_d   = (BC_COUNT == 1) ? StActive : StLocking;
        end
      end
      StLocking: begin
        if (word_done) begin
          if (is_comma) begin
            bc_cnt_d = bc_cnt_q + 1'b1;
            if (bc_cnt_q == BcW'(BC_COUNT - 1)) begin
              state_d = StActive;
            end
          end else begin
            bc_cnt_d = '0;
            state_d  = StSearch;
          end
        end
      end
      StActive: begin
        if (word_done) begin
          stb_d = 1'b1;
          if (is_comma) begin
            valid_d = 1'b0;
          end else begin
            data_d  = sr_d;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = StSearch;
    endcase
  end

  always_comb begin
    lane.data_out  = data_q;
    lane.valid_out = valid_q;
    lane.word_stb  = stb_q;
    lane.active    = (state_q == StActive);
  end

endmodule
